sym_src_4ask: RTL

//  Upstream stimulus stage for the halfband filter: generates a 4-ASK symbol stream (PRBS-driven),
//  an impulse or a constant, zero-stuffed to the filter input rate, in the 2s16-safe 1s17 format.
//  x_out drives the filter's x_in directly; it updates only on sys_clk2_en edges.

---
 rtl/sym_src_4ask.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sym_src_4ask.sv
// sym_src_4ask -- stimulus source for the halfband filter.
//
// Produces a zero-stuffed sample stream in 1s17 format at the filter input
// rate (sys_clk2_en). One symbol is emitted per qualified sam_clk_en strobe;
// every other input-rate tick carries a zero. Symbol content is selected by
// the mode latched at start: all-zero, a single impulse, PRBS-driven 4-ASK
// (Gray mapped), or a constant outer level.
//
// Run control: IDLE -start-> ARM -first symbol-> RUN -last symbol-> DONE -> IDLE.
// A stop pulse aborts ARM/RUN on the next edge. The last symbol of a run is
// held on x_out through DONE, so the filter still samples it once; x_out
// returns to zero on the DONE->IDLE tick.

module sym_src_4ask #(
    parameter int                        WIDTH    = 18,
    parameter int                        LFSR_LEN = 22,
    parameter logic [LFSR_LEN-1:0]       SEED     = 22'h3FFFFF,
    parameter logic signed [WIDTH-1:0]   LVL_A    = 18'sd21845,
    parameter int                        N_SYM    = 1024
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       sys_clk2_en,
    input  logic                       sam_clk_en,
    input  logic [1:0]                 mode,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       seed_load,
    input  logic [LFSR_LEN-1:0]        seed,
    output logic signed [WIDTH-1:0]    x_out,
    output logic                       x_valid,
    output logic [1:0]                 sym_bits,
    output logic                       busy,
    output logic                       done
);

    // Run-control states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Symbol modes.
    localparam logic [1:0] MODE_ZERO  = 2'd0;
    localparam logic [1:0] MODE_IMP   = 2'd1;
    localparam logic [1:0] MODE_PRBS  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    // 4-ASK levels. The outer level 3a = 65535 and its negation both fit in
    // 1s17, so no saturation is needed anywhere in the datapath.
    localparam logic signed [WIDTH-1:0] LVL_P1 = LVL_A;
    localparam logic signed [WIDTH-1:0] LVL_M1 = -LVL_A;
    localparam logic signed [WIDTH-1:0] LVL_P3 = WIDTH'(3 * LVL_A);
    localparam logic signed [WIDTH-1:0] LVL_M3 = -LVL_P3;

    // Symbol counter; wraps freely in the unbounded (N_SYM = 0) case.
    localparam int             CNT_W    = 16;
    localparam bit             HAS_END  = (N_SYM > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = HAS_END ? CNT_W'(N_SYM - 1) : '0;

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [1:0]              mode_q;
    logic [CNT_W-1:0]        sym_cnt;
    logic [LFSR_LEN-1:0]     lfsr;

    logic                    tick;
    logic                    sym;
    logic                    active;
    logic                    stop_hit;
    logic                    start_ok;
    logic                    arm_go;
    logic                    run_sym;
    logic                    emit;
    logic                    last_sym;
    logic [1:0]              lfsr_b;
    logic                    lfsr_fb;
    logic signed [WIDTH-1:0] sym_val;

    assign tick     = sys_clk2_en;
    assign sym      = sys_clk2_en & sam_clk_en;
    assign active   = (state == ST_ARM) | (state == ST_RUN);
    // A stop aborts the run even if it coincides with a symbol strobe.
    assign stop_hit = stop & active;
    assign start_ok = (state == ST_IDLE) & start & ~stop;
    assign arm_go   = (state == ST_ARM) & sym & ~stop;
    assign run_sym  = (state == ST_RUN) & sym & ~stop;
    assign emit     = arm_go | run_sym;
    assign last_sym = emit & HAS_END & (sym_cnt == CNT_LAST);

    // Symbol bit pair is taken from the two top LFSR bits before the shift.
    assign lfsr_b  = lfsr[LFSR_LEN-1 -: 2];
    assign lfsr_fb = lfsr_b[1] ^ lfsr_b[0];

    assign busy = active;

    // Next-state logic for the run controller.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: if (start_ok) state_next = ST_ARM;
            ST_ARM: begin
                if (stop)        state_next = ST_IDLE;
                else if (arm_go) state_next = last_sym ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (stop)          state_next = ST_IDLE;
                else if (last_sym) state_next = ST_DONE;
            end
            ST_DONE: if (tick) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Symbol value for the latched mode (Gray-mapped levels in PRBS mode).
    always_comb begin
        sym_val = '0;
        case (mode_q)
            MODE_ZERO:  sym_val = '0;
            MODE_IMP:   sym_val = arm_go ? LVL_P3 : '0;
            MODE_PRBS: begin
                case (lfsr_b)
                    2'b00:   sym_val = LVL_M3;
                    2'b01:   sym_val = LVL_M1;
                    2'b11:   sym_val = LVL_P1;
                    default: sym_val = LVL_P3;
                endcase
            end
            MODE_CONST: sym_val = LVL_P3;
            default:    sym_val = '0;
        endcase
    end

    // State register and one-cycle done pulse on entry to DONE.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == ST_DONE) && (state != ST_DONE);
        end
    end

    // Mode capture at start and per-run symbol counter.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            mode_q  <= MODE_ZERO;
            sym_cnt <= '0;
        end else if (start_ok) begin
            mode_q  <= mode;
            sym_cnt <= '0;
        end else if (emit) begin
            sym_cnt <= sym_cnt + CNT_W'(1);
        end
    end

    // PRBS register: seed load in IDLE (zero seed replaced to avoid lockup),
    // shift once per emitted PRBS symbol.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            lfsr     <= SEED;
            sym_bits <= 2'b00;
        end else if ((state == ST_IDLE) && seed_load) begin
            lfsr <= (seed == '0) ? SEED : seed;
        end else if (emit && (mode_q == MODE_PRBS)) begin
            lfsr     <= {lfsr[LFSR_LEN-2:0], lfsr_fb};
            sym_bits <= lfsr_b;
        end
    end

    // Sample output: symbol on a strobe, zero-stuff on other ticks, cleared on stop.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            x_out   <= '0;
            x_valid <= 1'b0;
        end else begin
            x_valid <= tick & (((state == ST_ARM) & sam_clk_en) | (state == ST_RUN));
            if (stop_hit) begin
                x_out <= '0;
            end else if (tick) begin
                x_out <= emit ? sym_val : '0;
            end
        end
    end

endmodule
